// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / forwarding controller for the in-order RV32 pipeline (IF/ID/EX/MEM).
// A shadow tracker follows each in-flight register write through the stages
// after ID. Per source port it selects the nearest forwarding stage, raises a
// one-cycle load-use bubble, sequences multi-cycle flushes after EX redirects
// and freezes the whole pipe while data memory is busy.

// Per source-port forwarding selector and load-use detector.
module pipeline_hazard_ctrl_port #(
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SW         = 2
) (
    input  logic [REG_AW-1:0]                  rs,
    input  logic                               used,
    input  logic [FWD_STAGES:1]                stg_vld,
    input  logic [FWD_STAGES:1]                stg_we,
    input  logic [FWD_STAGES:1]                stg_ld,
    input  logic [FWD_STAGES:1][REG_AW-1:0]    stg_rd,
    output logic [SW-1:0]                      sel,
    output logic                               ld_hit
);
    // Nearest matching producer wins; a load still in EX has no data yet.
    always_comb begin
        sel = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (used && stg_vld[k] && stg_we[k] && (stg_rd[k] != '0) &&
                (stg_rd[k] == rs) && !((k == 1) && stg_ld[k]))
                sel = SW'(k);
        end
    end

    // This port reads the destination of a load sitting in EX.
    always_comb begin
        ld_hit = used && stg_vld[1] && stg_we[1] && stg_ld[1] &&
                 (stg_rd[1] != '0) && (stg_rd[1] == rs);
    end
endmodule

module pipeline_hazard_ctrl #(
    parameter int NUM_SRC      = 2,
    parameter int FWD_STAGES   = 2,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    localparam int SW          = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_we,
    input  logic                      id_is_load,
    input  logic                      redirect,
    input  logic                      mem_busy,
    output logic                      if_stall,
    output logic                      id_stall,
    output logic                      ex_stall,
    output logic                      mem_stall,
    output logic                      id_flush,
    output logic [NUM_SRC*SW-1:0]     fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);
    typedef enum logic {IDLE, FLUSH} state_t;

    // Shadow tracker, index 1 = EX.
    logic [FWD_STAGES:1]             vld_pipe;
    logic [FWD_STAGES:1]             we_pipe;
    logic [FWD_STAGES:1]             ld_pipe;
    logic [FWD_STAGES:1][REG_AW-1:0] rd_pipe;

    state_t       state;
    logic [2:0]   flush_n;
    logic         redir_pend;   // redirect that arrived during a freeze

    logic               active, freeze, adv, redir_eff, flushing, hz;
    logic [NUM_SRC-1:0] ld_hit;

    // Per-port forwarding selectors.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        pipeline_hazard_ctrl_port #(
            .FWD_STAGES (FWD_STAGES),
            .REG_AW     (REG_AW),
            .SW         (SW)
        ) u_port (
            .rs      (id_rs[i*REG_AW +: REG_AW]),
            .used    (id_rs_used[i]),
            .stg_vld (vld_pipe),
            .stg_we  (we_pipe),
            .stg_ld  (ld_pipe),
            .stg_rd  (rd_pipe),
            .sel     (fwd_sel[i*SW +: SW]),
            .ld_hit  (ld_hit[i])
        );
    end

    // Cycle control: reset > ~run > mem_busy > redirect/flush > load-use.
    always_comb begin
        active    = reset & run;
        freeze    = active & mem_busy;
        adv       = active & ~mem_busy;
        redir_eff = adv & (redirect | redir_pend);
        flushing  = redir_eff | (adv & (state == FLUSH));
        hz        = adv & ~flushing & id_valid & (|ld_hit);
        if_stall  = freeze | hz;
        id_stall  = freeze | hz;
        ex_stall  = freeze;
        mem_stall = freeze;
        id_flush  = flushing;
    end

    // Tracker shift; squashed or hazarded ID slots enter EX as bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            we_pipe  <= '0;
            ld_pipe  <= '0;
            rd_pipe  <= '0;
        end else if (adv) begin
            vld_pipe[1] <= id_valid & ~flushing & ~hz;
            we_pipe[1]  <= id_reg_we;
            ld_pipe[1]  <= id_is_load;
            rd_pipe[1]  <= id_rd;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                we_pipe[k]  <= we_pipe[k-1];
                ld_pipe[k]  <= ld_pipe[k-1];
                rd_pipe[k]  <= rd_pipe[k-1];
            end
        end
    end

    // Flush sequencer; a redirect during a freeze is held until the pipe moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            flush_n    <= '0;
            redir_pend <= 1'b0;
        end else begin
            if (freeze && redirect)
                redir_pend <= 1'b1;
            else if (adv)
                redir_pend <= 1'b0;

            if (redir_eff) begin
                state   <= FLUSH;
                flush_n <= 3'(FLUSH_CYCLES);
            end else if (adv && (state == FLUSH)) begin
                flush_n <= flush_n - 3'd1;
                if (flush_n == 3'd1)
                    state <= IDLE;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (run && if_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redir_eff && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
